mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 0, meaning 0 = LSU fixed priority and 1 = round-robin between IFU and LSU.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all flops on posedge.
- rst  in  1  asynchronous, active-low reset.
- ifu_req_valid, ifu_req_ready  in/out  1/1  IFU request handshake.
- ifu_addr  in  32  IFU read address.
- ifu_resp_valid, ifu_resp_ready  out/in  1/1  IFU response handshake.
- ifu_rdata, ifu_resp_err  out  32/1  IFU read data and error flag.
- lsu_req_valid, lsu_req_ready  in/out  1/1  LSU request handshake.
- lsu_addr, lsu_wdata  in  32/32  LSU address and write data.
- lsu_wen, lsu_wmask  in  1/4  LSU write enable and byte mask.
- lsu_resp_valid, lsu_resp_ready  out/in  1/1  LSU response handshake.
- lsu_rdata, lsu_resp_err  out  32/1  LSU read data and error flag.
- mem_req_valid, mem_req_ready  out/in  1/1  memory request handshake.
- mem_addr, mem_wdata  out  32/32  memory address and write data.
- mem_wen, mem_wmask  out  1/4  memory write enable and byte mask.
- mem_resp_valid, mem_resp_ready  in/out  1/1  memory response handshake.
- mem_rdata, mem_resp_err  in  32/1  memory read data and error flag.

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE, with at most one transaction outstanding.
REQ-004 IDLE: at most one of ifu_req_ready/lsu_req_ready high, only to the granted requester; both low when neither valid.
REQ-005 Grant, RR_EN=0: LSU whenever lsu_req_valid, else IFU.
REQ-006 Grant, RR_EN=1: when both valid, grant the requester not served last; last-served flag updates on each accept.
REQ-007 On req valid&ready in IDLE: latch addr/wen/wdata/wmask and owner (IFU accept forces wen=0, wmask=0); next state ISSUE.
REQ-008 ISSUE: mem_req_valid=1 with latched fields stable; on mem_req_ready -> WAIT.
REQ-009 WAIT: mem_resp_ready=1; on mem_resp_valid latch rdata/err -> DELIVER.
REQ-010 DELIVER: owner's resp_valid=1 with latched rdata/err; non-owner resp_valid=0; on owner resp_ready -> IDLE.
REQ-011 mem_req_valid high only in ISSUE; mem_resp_ready high only in WAIT; all req_ready low outside IDLE.
REQ-012 Minimum latency accept->resp_valid: 3 cycles (mem_req_ready and mem_resp_valid both first-cycle).
REQ-013 Non-granted request SHALL be held by its master, never dropped or reordered by the arbiter.
REQ-014 Response without resp_ready (back-pressure) SHALL hold DELIVER indefinitely with data stable.
REQ-015 mem_resp_valid outside WAIT SHALL be ignored (no state or data change).
REQ-016 Error path identical to normal path; err forwarded only to owner.

Reset
REQ-017 rst low SHALL asynchronously force: state IDLE, owner IFU, last-served LSU (IFU wins the first RR tie), all latched fields 0, all outputs 0.
REQ-018 Reset mid-transaction SHALL abandon it; the memory side is reset by the same rst.
REQ-019 First grant SHALL be possible on the first posedge after rst deasserts.

Structure
REQ-020 SHALL place state encoding (2-bit enum) and owner encoding in shared package mem_arb_pkg.
REQ-021 SHALL be a single flat module with no sub-module; grant logic is a small combinational block.

Verification
REQ-022 RR_EN=0, both request in IDLE -> LSU granted (lsu_req_ready=1, ifu_req_ready=0); IFU served after LSU response delivered.
REQ-023 RR_EN=1, both request continuously for 4 transactions -> grant order IFU, LSU, IFU, LSU.
REQ-024 IFU read addr 0x80000000, mem returns 0xDEADBEEF with zero wait states -> ifu_resp_valid 3 cycles after accept, mem_wen=0, mem_wmask=0.
REQ-025 LSU write addr 0x10, wdata 0x12345678, wmask 0xF, mem_req_ready delayed 5 cycles -> mem fields stable all 5 cycles; lsu_resp_valid follows the memory response.
REQ-026 lsu_resp_ready held low 10 cycles in DELIVER -> lsu_resp_valid and rdata stable; ifu request not accepted until handshake.
REQ-027 rst asserted during WAIT -> all outputs 0 immediately; stale mem_resp_valid after release is ignored; next request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM state and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to single-memory arbiter, one transaction outstanding at a time.
// Grant is LSU-fixed-priority or round-robin depending on RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, last_q, grant;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wmask_q;
  logic        wen_q, err_q;
  logic        ifu_acc, lsu_acc, deliver_hs;

  always_comb begin
    grant = OWN_IFU;
    if (lsu_req_valid && !ifu_req_valid) begin
      grant = OWN_LSU;
    end else if (lsu_req_valid && ifu_req_valid) begin
      grant = (RR_EN && last_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
    end
  end

  // Ready is gated by rst so every output reads 0 while reset is held, even with valids high.
  always_comb begin
    ifu_req_ready = rst && (state_q == ST_IDLE) && ifu_req_valid && (grant == OWN_IFU);
    lsu_req_ready = rst && (state_q == ST_IDLE) && lsu_req_valid && (grant == OWN_LSU);
    ifu_acc       = ifu_req_valid && ifu_req_ready;
    lsu_acc       = lsu_req_valid && lsu_req_ready;
  end

  always_comb begin
    mem_req_valid  = (state_q == ST_ISSUE);
    mem_resp_ready = (state_q == ST_WAIT);
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    mem_wen        = wen_q;
    mem_wmask      = wmask_q;
    ifu_resp_valid = (state_q == ST_DELIVER) && (owner_q == OWN_IFU);
    lsu_resp_valid = (state_q == ST_DELIVER) && (owner_q == OWN_LSU);
    ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
    ifu_resp_err   = ifu_resp_valid && err_q;
    lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
    lsu_resp_err   = lsu_resp_valid && err_q;
    deliver_hs     = (ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ifu_acc || lsu_acc) state_d = ST_ISSUE;
      ST_ISSUE:   if (mem_req_ready)      state_d = ST_WAIT;
      ST_WAIT:    if (mem_resp_valid)     state_d = ST_DELIVER;
      ST_DELIVER: if (deliver_hs)         state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ifu_acc || lsu_acc) begin
        owner_q <= grant;
        last_q  <= grant;
        addr_q  <= lsu_acc ? lsu_addr : ifu_addr;
        wdata_q <= lsu_acc ? lsu_wdata : '0;
        wen_q   <= lsu_acc && lsu_wen;
        wmask_q <= lsu_acc ? lsu_wmask : '0;
      end
      if ((state_q == ST_WAIT) && mem_resp_valid) begin
        rdata_q <= mem_rdata;
        err_q   <= mem_resp_err;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses fixed LSU priority, instance 1 round-robin.
// Directed vectors and sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic        ifu_req_valid [2];
  logic        ifu_req_ready [2];
  logic [31:0] ifu_addr [2];
  logic        ifu_resp_valid [2];
  logic        ifu_resp_ready [2];
  logic [31:0] ifu_rdata [2];
  logic        ifu_resp_err [2];
  logic        lsu_req_valid [2];
  logic        lsu_req_ready [2];
  logic [31:0] lsu_addr [2];
  logic [31:0] lsu_wdata [2];
  logic        lsu_wen [2];
  logic [3:0]  lsu_wmask [2];
  logic        lsu_resp_valid [2];
  logic        lsu_resp_ready [2];
  logic [31:0] lsu_rdata [2];
  logic        lsu_resp_err [2];
  logic        mem_req_valid [2];
  logic        mem_req_ready [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        mem_wen [2];
  logic [3:0]  mem_wmask [2];
  logic        mem_resp_valid [2];
  logic        mem_resp_ready [2];
  logic [31:0] mem_rdata [2];
  logic        mem_resp_err [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.RR_EN(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]), .ifu_addr(ifu_addr[g]),
      .ifu_resp_valid(ifu_resp_valid[g]), .ifu_resp_ready(ifu_resp_ready[g]),
      .ifu_rdata(ifu_rdata[g]), .ifu_resp_err(ifu_resp_err[g]),
      .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]), .lsu_addr(lsu_addr[g]),
      .lsu_wdata(lsu_wdata[g]), .lsu_wen(lsu_wen[g]), .lsu_wmask(lsu_wmask[g]),
      .lsu_resp_valid(lsu_resp_valid[g]), .lsu_resp_ready(lsu_resp_ready[g]),
      .lsu_rdata(lsu_rdata[g]), .lsu_resp_err(lsu_resp_err[g]),
      .mem_req_valid(mem_req_valid[g]), .mem_req_ready(mem_req_ready[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wen(mem_wen[g]), .mem_wmask(mem_wmask[g]),
      .mem_resp_valid(mem_resp_valid[g]), .mem_resp_ready(mem_resp_ready[g]),
      .mem_rdata(mem_rdata[g]), .mem_resp_err(mem_resp_err[g])
    );
  end

  typedef struct {
    int d;
    bit iv;
    bit lv;
    bit exp_ir;
    bit exp_lr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs(input int d);
    ifu_req_valid[d] = 1'b0; ifu_addr[d] = '0; ifu_resp_ready[d] = 1'b0;
    lsu_req_valid[d] = 1'b0; lsu_addr[d] = '0; lsu_wdata[d] = '0;
    lsu_wen[d] = 1'b0; lsu_wmask[d] = '0; lsu_resp_ready[d] = 1'b0;
    mem_req_ready[d] = 1'b0; mem_resp_valid[d] = 1'b0; mem_rdata[d] = '0; mem_resp_err[d] = 1'b0;
  endtask

  function automatic logic [31:0] outs_or(input int d);
    return {18'd0, ifu_req_ready[d], ifu_resp_valid[d], |ifu_rdata[d], ifu_resp_err[d],
            lsu_req_ready[d], lsu_resp_valid[d], |lsu_rdata[d], lsu_resp_err[d],
            mem_req_valid[d], |mem_addr[d], |mem_wdata[d], mem_wen[d], |mem_wmask[d],
            mem_resp_ready[d]};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Called right after the accept edge; memory answers immediately, response taken at once.
  task automatic run_txn(input int d, input bit lsu_owner, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input bit err);
    bit seen_req;
    int n;
    seen_req = 1'b0;
    n = 0;
    mem_req_ready[d] = 1'b1; mem_resp_valid[d] = 1'b1;
    mem_rdata[d] = rdata;    mem_resp_err[d] = err;
    #1;
    while (!(lsu_owner ? lsu_resp_valid[d] : ifu_resp_valid[d]) && n < 10) begin
      if (mem_req_valid[d]) begin
        seen_req = 1'b1;
        chk("txn_mem_addr", mem_addr[d], exp_addr);
      end
      chk("txn_busy_ready", {ifu_req_ready[d], lsu_req_ready[d]}, 0);
      tick();
      #1;
      n++;
    end
    chk("txn_mem_req_seen", seen_req, 1);
    chk("txn_latency", n, 2);
    chk("txn_owner_resp_valid", lsu_owner ? lsu_resp_valid[d] : ifu_resp_valid[d], 1);
    chk("txn_other_resp_valid", lsu_owner ? ifu_resp_valid[d] : lsu_resp_valid[d], 0);
    chk("txn_rdata", lsu_owner ? lsu_rdata[d] : ifu_rdata[d], rdata);
    chk("txn_err", lsu_owner ? lsu_resp_err[d] : ifu_resp_err[d], err);
    chk("txn_other_err", lsu_owner ? ifu_resp_err[d] : lsu_resp_err[d], 0);
    mem_req_ready[d] = 1'b0; mem_resp_valid[d] = 1'b0;
    if (lsu_owner) lsu_resp_ready[d] = 1'b1; else ifu_resp_ready[d] = 1'b1;
    tick();
    lsu_resp_ready[d] = 1'b0;
    ifu_resp_ready[d] = 1'b0;
  endtask

  // Transaction-level model: stage counts handshakes completed for the current transaction
  // (0 none/idle, 1 accepted, 2 memory took request, 3 memory answered).
  task automatic rand_run(input int d, input int ncyc);
    bit rr, iv, lv, lwe, c_wen, e_err, own_lsu, last_lsu, win_any, win_lsu;
    logic [31:0] ia, la, lwd, c_addr, c_wdata, e_rdata;
    logic [3:0] lwm, c_wmask;
    int stage, dly;
    rr = (d == 1);
    iv = 0; lv = 0; lwe = 0; c_wen = 0; e_err = 0; own_lsu = 0; last_lsu = 1;
    ia = '0; la = '0; lwd = '0; c_addr = '0; c_wdata = '0; e_rdata = '0; lwm = '0; c_wmask = '0;
    stage = 0; dly = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!iv) begin
        iv = ($urandom % 3) == 0;
        ia = $urandom;
      end
      if (!lv) begin
        lv = ($urandom % 3) == 0;
        la = $urandom; lwd = $urandom; lwe = 1'($urandom % 2); lwm = 4'($urandom);
      end
      ifu_req_valid[d] = iv; ifu_addr[d] = ia;
      lsu_req_valid[d] = lv; lsu_addr[d] = la; lsu_wdata[d] = lwd;
      lsu_wen[d] = lwe; lsu_wmask[d] = lwm;
      mem_req_ready[d]  = 1'($urandom % 2);
      ifu_resp_ready[d] = ($urandom % 5) < 3;
      lsu_resp_ready[d] = ($urandom % 5) < 3;
      if (stage == 2) begin
        mem_resp_valid[d] = (dly == 0);
        mem_rdata[d] = (dly == 0) ? e_rdata : 32'($urandom);
        mem_resp_err[d] = (dly == 0) ? e_err : 1'($urandom % 2);
      end else begin
        mem_resp_valid[d] = ($urandom % 4) == 0;
        mem_rdata[d] = $urandom;
        mem_resp_err[d] = 1'($urandom % 2);
      end
      win_any = (stage == 0) && (iv || lv);
      if (iv && lv) win_lsu = rr ? !last_lsu : 1'b1;
      else          win_lsu = lv;
      #1;
      chk("rand_ifu_req_ready", ifu_req_ready[d], win_any && !win_lsu);
      chk("rand_lsu_req_ready", lsu_req_ready[d], win_any && win_lsu);
      chk("rand_mem_req_valid", mem_req_valid[d], stage == 1);
      chk("rand_mem_resp_ready", mem_resp_ready[d], stage == 2);
      chk("rand_ifu_resp_valid", ifu_resp_valid[d], stage == 3 && !own_lsu);
      chk("rand_lsu_resp_valid", lsu_resp_valid[d], stage == 3 && own_lsu);
      if (stage == 1) begin
        chk("rand_mem_addr", mem_addr[d], c_addr);
        chk("rand_mem_wen", mem_wen[d], c_wen);
        chk("rand_mem_wmask", mem_wmask[d], c_wmask);
        if (own_lsu) chk("rand_mem_wdata", mem_wdata[d], c_wdata);
      end
      if (stage == 3) begin
        chk("rand_rdata", own_lsu ? lsu_rdata[d] : ifu_rdata[d], e_rdata);
        chk("rand_err", own_lsu ? lsu_resp_err[d] : ifu_resp_err[d], e_err);
        chk("rand_other_err", own_lsu ? ifu_resp_err[d] : lsu_resp_err[d], 0);
      end
      case (stage)
        0: if (win_any) begin
             stage = 1; own_lsu = win_lsu; last_lsu = win_lsu;
             if (win_lsu) begin
               c_addr = la; c_wdata = lwd; c_wen = lwe; c_wmask = lwm; lv = 0;
             end else begin
               c_addr = ia; c_wen = 0; c_wmask = '0; iv = 0;
             end
           end
        1: if (mem_req_ready[d]) begin
             stage = 2; dly = $urandom % 4; e_rdata = $urandom; e_err = ($urandom % 4) == 0;
           end
        2: if (dly == 0) stage = 3; else dly--;
        default: if (own_lsu ? lsu_resp_ready[d] : ifu_resp_ready[d]) stage = 0;
      endcase
      tick();
    end
    clear_inputs(d);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    ifu_req_valid[0] = 1'b1; lsu_req_valid[0] = 1'b1;
    ifu_req_valid[1] = 1'b1; lsu_req_valid[1] = 1'b1;
    tick();
    tick();
    chk("reset_outputs_rr0", outs_or(0), 0);
    chk("reset_outputs_rr1", outs_or(1), 0);
    clear_inputs(0);
    clear_inputs(1);
    rst = 1'b1;

    // Grant table from the post-reset state (RR: last served is LSU, so IFU wins a tie)
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1, 1'b1, 1'b1, 1'b1, 1'b0};
    foreach (vecs[i]) begin
      ifu_req_valid[vecs[i].d] = vecs[i].iv;
      lsu_req_valid[vecs[i].d] = vecs[i].lv;
      #1;
      chk("grant_table_ifu_ready", ifu_req_ready[vecs[i].d], vecs[i].exp_ir);
      chk("grant_table_lsu_ready", lsu_req_ready[vecs[i].d], vecs[i].exp_lr);
      ifu_req_valid[vecs[i].d] = 1'b0;
      lsu_req_valid[vecs[i].d] = 1'b0;
      tick();
    end

    // Round-robin, both masters requesting continuously
    ifu_req_valid[1] = 1'b1; ifu_addr[1] = 32'h100;
    lsu_req_valid[1] = 1'b1; lsu_addr[1] = 32'h200;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("rr_order_ifu_ready", ifu_req_ready[1], (t % 2) == 0);
      chk("rr_order_lsu_ready", lsu_req_ready[1], (t % 2) == 1);
      tick();
      run_txn(1, (t % 2) == 1, ((t % 2) == 1) ? 32'h200 : 32'h100, 32'h1000 + 32'(t), 1'b0);
    end
    clear_inputs(1);

    // IFU read, zero wait states; LSU write fields driven but must not leak
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h8000_0000;
    lsu_wen[0] = 1'b1; lsu_wmask[0] = 4'hF; lsu_wdata[0] = 32'hFFFF_FFFF;
    mem_req_ready[0] = 1'b1; mem_resp_valid[0] = 1'b1; mem_rdata[0] = 32'hDEAD_BEEF;
    #1;
    chk("ifu_rd_req_ready", ifu_req_ready[0], 1);
    tick();
    ifu_req_valid[0] = 1'b0;
    #1;
    chk("ifu_rd_mem_req_valid", mem_req_valid[0], 1);
    chk("ifu_rd_mem_addr", mem_addr[0], 32'h8000_0000);
    chk("ifu_rd_mem_wen", mem_wen[0], 0);
    chk("ifu_rd_mem_wmask", mem_wmask[0], 0);
    chk("ifu_rd_resp_early1", ifu_resp_valid[0], 0);
    tick();
    #1;
    chk("ifu_rd_mem_resp_ready", mem_resp_ready[0], 1);
    chk("ifu_rd_resp_early2", ifu_resp_valid[0], 0);
    tick();
    #1;
    chk("ifu_rd_resp_valid_lat3", ifu_resp_valid[0], 1);
    chk("ifu_rd_rdata", ifu_rdata[0], 32'hDEAD_BEEF);
    chk("ifu_rd_lsu_resp_valid", lsu_resp_valid[0], 0);
    ifu_resp_ready[0] = 1'b1; mem_resp_valid[0] = 1'b0; mem_req_ready[0] = 1'b0;
    tick();
    clear_inputs(0);
    #1;
    chk("ifu_rd_resp_done", ifu_resp_valid[0], 0);

    // Fixed priority: LSU wins the tie, IFU held and served afterwards (with error)
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'hA0;
    lsu_req_valid[0] = 1'b1; lsu_addr[0] = 32'hB0;
    #1;
    chk("prio_lsu_ready", lsu_req_ready[0], 1);
    chk("prio_ifu_ready", ifu_req_ready[0], 0);
    tick();
    lsu_req_valid[0] = 1'b0;
    run_txn(0, 1'b1, 32'hB0, 32'h1111, 1'b0);
    #1;
    chk("prio_ifu_after_lsu", ifu_req_ready[0], 1);
    tick();
    ifu_req_valid[0] = 1'b0;
    run_txn(0, 1'b0, 32'hA0, 32'h2222, 1'b1);

    // LSU write, memory stalls request 5 cycles, then response back-pressure for 10 cycles
    lsu_req_valid[0] = 1'b1; lsu_addr[0] = 32'h10; lsu_wdata[0] = 32'h1234_5678;
    lsu_wmask[0] = 4'hF; lsu_wen[0] = 1'b1;
    #1;
    chk("wr_lsu_req_ready", lsu_req_ready[0], 1);
    tick();
    lsu_req_valid[0] = 1'b0; lsu_addr[0] = '1; lsu_wdata[0] = '0; lsu_wmask[0] = '0; lsu_wen[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wr_stall_req_valid", mem_req_valid[0], 1);
      chk("wr_stall_addr", mem_addr[0], 32'h10);
      chk("wr_stall_wdata", mem_wdata[0], 32'h1234_5678);
      chk("wr_stall_wen", mem_wen[0], 1);
      chk("wr_stall_wmask", mem_wmask[0], 4'hF);
      tick();
    end
    mem_req_ready[0] = 1'b1;
    tick();
    mem_req_ready[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wr_wait_resp_ready", mem_resp_ready[0], 1);
      chk("wr_wait_no_resp", lsu_resp_valid[0], 0);
      tick();
    end
    mem_resp_valid[0] = 1'b1; mem_rdata[0] = 32'hCAFE_0001; mem_resp_err[0] = 1'b1;
    tick();
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h300;
    for (int i = 0; i < 10; i++) begin
      mem_rdata[0] = $urandom;
      mem_resp_err[0] = 1'b0;
      #1;
      chk("bp_lsu_resp_valid", lsu_resp_valid[0], 1);
      chk("bp_lsu_rdata", lsu_rdata[0], 32'hCAFE_0001);
      chk("bp_lsu_err", lsu_resp_err[0], 1);
      chk("bp_ifu_err", ifu_resp_err[0], 0);
      chk("bp_ifu_req_ready", ifu_req_ready[0], 0);
      tick();
    end
    mem_resp_valid[0] = 1'b0;
    lsu_resp_ready[0] = 1'b1;
    tick();
    lsu_resp_ready[0] = 1'b0;
    #1;
    chk("bp_ifu_after_hs", ifu_req_ready[0], 1);
    tick();
    ifu_req_valid[0] = 1'b0;
    run_txn(0, 1'b0, 32'h300, 32'h7777, 1'b0);

    // Reset during WAIT, stale memory response afterwards, then a normal transaction
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h500; mem_req_ready[0] = 1'b1;
    tick();
    ifu_req_valid[0] = 1'b0;
    tick();
    mem_req_ready[0] = 1'b0;
    #1;
    chk("rstw_in_wait", mem_resp_ready[0], 1);
    rst = 1'b0;
    #1;
    chk("rstw_outputs_zero", outs_or(0), 0);
    mem_resp_valid[0] = 1'b1; mem_rdata[0] = 32'hBAD0_BAD0; mem_resp_err[0] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rstw_stale_ignored", outs_or(0), 0);
    end
    mem_resp_valid[0] = 1'b0; mem_rdata[0] = '0; mem_resp_err[0] = 1'b0;
    ifu_req_valid[0] = 1'b1; ifu_addr[0] = 32'h44;
    #1;
    chk("rstw_next_ready", ifu_req_ready[0], 1);
    tick();
    ifu_req_valid[0] = 1'b0;
    run_txn(0, 1'b0, 32'h44, 32'h5555, 1'b0);

    do_reset();
    rand_run(0, 600);
    do_reset();
    rand_run(1, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
